// File: rtl/ssd_sum_display.sv
// ssd_sum_display: shows a sign-magnitude 8-bit result on a 4-digit,
// common-anode seven-segment display. The magnitude is converted to BCD
// with a sequential shift-add-3 engine (one bit per cycle). The finished
// digits are latched and time-multiplexed onto the anodes. Digit 3 carries
// the minus sign.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zeros in the
// hundreds and tens digits. The ones digit is always shown.
module ssd_sum_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] value,
  input  logic       neg,
  output logic       busy,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_CONVERT = 1'b1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Segment pattern {g,f,e,d,c,b,a}, active-low, for one BCD digit.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Shift-add-3 correction for one BCD nibble ahead of the left shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    logic [3:0] r;
    if (n >= 4'd5) begin
      r = n + 4'd3;
    end else begin
      r = n;
    end
    return r;
  endfunction

  logic [0:0]    state_q, state_d;
  logic [7:0]    bin_q, bin_d;
  logic [11:0]   bcd_q, bcd_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          sign_cap_q, sign_cap_d;
  logic          busy_q, busy_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    hund_q, hund_d;
  logic          sign_q, sign_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic [11:0]   bcd_adj_s;
  logic [11:0]   bcd_shift_s;

  // Conversion FSM: capture on load, then 8 correct-and-shift steps.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    sign_cap_d = sign_cap_q;
    busy_d     = busy_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    hund_d     = hund_q;
    sign_d     = sign_q;
    bcd_adj_s   = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    bcd_shift_s = {bcd_adj_s[10:0], bin_q[7]};
    case (state_q)
      S_IDLE: begin
        if (load) begin
          bin_d      = value;
          // Negative zero is displayed without a minus sign.
          sign_cap_d = neg & (value != 8'd0);
          bcd_d      = 12'd0;
          cnt_d      = 3'd0;
          busy_d     = 1'b1;
          state_d    = S_CONVERT;
        end else begin
          busy_d     = 1'b0;
        end
      end
      S_CONVERT: begin
        bcd_d = bcd_shift_s;
        bin_d = {bin_q[6:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // Last shift: the shifted accumulator is the final result.
          ones_d  = bcd_shift_s[3:0];
          tens_d  = bcd_shift_s[7:4];
          hund_d  = bcd_shift_s[11:8];
          sign_d  = sign_cap_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Display scan: refresh divider, digit index and registered anode/segment drive.
  always_comb begin
    refresh_d = refresh_q;
    idx_d     = idx_q;
    seg_d     = SEG_BLANK;
    dp_d      = 1'b1;
    if (refresh_q == REF_LAST) begin
      refresh_d = {RW{1'b0}};
      idx_d     = idx_q + 2'd1;
    end else begin
      refresh_d = refresh_q + RW'(1);
    end
    an_d = ~(4'b0001 << idx_q);
    case (idx_q)
      2'd0: seg_d = seg_encode(ones_q);
      2'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
        if ((hund_q == 4'd0) && (tens_q == 4'd0)) begin
          seg_d = SEG_BLANK;
        end else begin
          seg_d = seg_encode(tens_q);
        end
`else
        seg_d = seg_encode(tens_q);
`endif
      end
      2'd2: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (hund_q == 4'd0) begin
          seg_d = SEG_BLANK;
        end else begin
          seg_d = seg_encode(hund_q);
        end
`else
        seg_d = seg_encode(hund_q);
`endif
      end
      2'd3: begin
        if (sign_q) begin
          seg_d = SEG_MINUS;
        end else begin
          seg_d = SEG_BLANK;
        end
      end
      default: seg_d = SEG_BLANK;
    endcase
  end

  // State registers with synchronous reset; reset aborts any conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bin_q      <= 8'd0;
      bcd_q      <= 12'd0;
      cnt_q      <= 3'd0;
      sign_cap_q <= 1'b0;
      busy_q     <= 1'b0;
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      hund_q     <= 4'd0;
      sign_q     <= 1'b0;
      refresh_q  <= {RW{1'b0}};
      idx_q      <= 2'd0;
      an_q       <= 4'b1111;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      sign_cap_q <= sign_cap_d;
      busy_q     <= busy_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      hund_q     <= hund_d;
      sign_q     <= sign_d;
      refresh_q  <= refresh_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign busy = busy_q;
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;

endmodule

// File: tb/tb_ssd_sum_display.sv
// Scoreboard bench for ssd_sum_display (REFRESH_DIV = 4).
// Stimulus predicts which loads are accepted and pushes the expected
// displayed value. A negedge monitor checks every displayed digit against
// a decimal reference model, and it pops the queue when busy falls.
module tb_ssd_sum_display;

  localparam int RD = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] value = 8'd0;
  logic       neg = 1'b0;
  logic       busy;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  ssd_sum_display #(.REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .neg(neg),
    .busy(busy), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct { int val; bit sgn; } exp_t;
  exp_t sb_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = -100;

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  function automatic logic [6:0] exp_seg(input int idx, input int v, input bit s);
    logic [6:0] r;
    case (idx)
      0: r = seg_tab[v % 10];
      1: r = (LZB && v < 10) ? 7'b1111111 : seg_tab[(v / 10) % 10];
      2: r = (LZB && v < 100) ? 7'b1111111 : seg_tab[v / 100];
      default: r = s ? 7'b0111111 : 7'b1111111;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  bit in_rst = 1'b1;
  int k = 0;
  int bcnt = 0;
  bit prev_busy = 1'b0;
  int m_val = 0;
  bit m_sgn = 1'b0;

  always @(negedge clk) begin
    if (in_rst) begin
      check("rst_an", an, 4'b1111);
      check("rst_seg", seg, 7'b1111111);
      check("rst_dp", dp, 1'b1);
      check("rst_busy", busy, 1'b0);
      sb_q.delete();
      m_val = 0; m_sgn = 1'b0;
      k = 0; bcnt = 0; prev_busy = 1'b0;
    end else begin
      int idx;
      idx = (k / RD) % 4;
      check("scan_an", an, ~(4'b0001 << idx) & 4'hF);
      check("seg", seg, exp_seg(idx, m_val, m_sgn));
      check("dp", dp, 1'b1);
      k++;
      if (busy) begin
        bcnt++;
      end else if (prev_busy) begin
        check("busy_len", bcnt, 8);
        bcnt = 0;
        if (sb_q.size() == 0) begin
          check("sb_underflow", 0, 1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          m_val = e.val; m_sgn = e.sgn;
        end
      end
      prev_busy = busy;
    end
    in_rst = rst;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      if (rst) last_acc = -100;
      #1;
    end
  endtask

  task automatic do_load(input int v, input bit n);
    exp_t e;
    load = 1'b1; value = v[7:0]; neg = n;
    @(posedge clk);
    cyc++;
    if (rst) begin
      last_acc = -100;
    end else if (cyc - last_acc >= 9) begin
      e.val = v; e.sgn = n && (v != 0);
      sb_q.push_back(e);
      last_acc = cyc;
    end
    #1;
    load = 1'b0; value = 8'($urandom); neg = 1'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(20);
    do_load(62, 1'b0);  step(30);
    do_load(255, 1'b1); step(30);
    do_load(0, 1'b1);   step(30);
    // Second load lands on busy cycle 3 and must be ignored.
    do_load(62, 1'b0);  step(2);
    do_load(17, 1'b1);  step(30);
    // Reset in the middle of a conversion: 99 must never appear.
    do_load(99, 1'b0);  step(3);
    rst = 1'b1; step(2);
    rst = 1'b0; step(30);
    // Load together with reset is dropped.
    rst = 1'b1;
    do_load(88, 1'b1);
    rst = 1'b0; step(20);
    for (int i = 0; i < 40; i++) begin
      int v;
      case ($urandom_range(0, 5))
        0: v = 0;
        1: v = 255;
        2: v = $urandom_range(0, 9);
        3: v = $urandom_range(10, 99);
        default: v = $urandom_range(0, 255);
      endcase
      do_load(v, 1'($urandom));
      step($urandom_range(0, 20));
    end
    step(30);
    check("sb_leftover", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
